// File: rtl/lcd_spi_tx.sv
// Byte-wide SPI transmitter for an LCD controller: small FIFO in front of a
// serializer that frames every byte with its own CS-low window and DC level.
module lcd_spi_tx #(
  parameter int HALF_PERIOD = 1,
  parameter int CS_GAP      = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] IN_DATA,
  input  logic       IN_DC,
  input  logic       IN_VALID,
  output logic       IN_READY,
  output logic       BUSY,
  output logic       SCL,
  output logic       MOSI,
  output logic       DC,
  output logic       CS
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [7:0]    HP_LOAD    = 8'(HALF_PERIOD - 1);
  localparam logic [7:0]    GAP_LOAD   = 8'(CS_GAP - 1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);
  localparam logic [AW:0]   CNT_ONE    = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL   = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, GAP} state_t;

  state_t        state, state_next;
  logic [8:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [8:0]    head;
  logic          fifo_empty, fifo_full, push, pop, state_enter;
  logic [7:0]    cnt;
  logic [2:0]    bit_idx, idx_next;
  logic [7:0]    shreg;

  assign fifo_empty  = (count == '0);
  assign fifo_full   = (count == CNT_FULL);
  assign IN_READY    = !fifo_full && !RESET;
  assign push        = IN_VALID && IN_READY;
  assign head        = fifo_mem[rd_ptr];
  assign state_enter = (state_next != state);
  assign pop         = state_enter && (state_next == SETUP);
  assign BUSY        = !RESET && ((state != IDLE) || !fifo_empty);

  always_ff @(posedge CLK) begin
    if (push) fifo_mem[wr_ptr] <= {IN_DC, IN_DATA};
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // The bit index steps down on the HIGH->LOW transition, so the LOW entry
  // edge must already present the next bit on MOSI.
  always_comb begin
    state_next = state;
    idx_next   = bit_idx;
    case (state)
      IDLE:  if (!fifo_empty) state_next = SETUP;
      SETUP: if (cnt == 8'd0) state_next = LOW;
      LOW:   if (cnt == 8'd0) state_next = HIGH;
      HIGH: begin
        if (cnt == 8'd0) begin
          if (bit_idx == 3'd0) begin
            state_next = GAP;
          end else begin
            state_next = LOW;
            idx_next   = bit_idx - 3'd1;
          end
        end
      end
      GAP:     if (cnt == 8'd0) state_next = fifo_empty ? IDLE : SETUP;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      bit_idx <= 3'd0;
      shreg   <= 8'd0;
      SCL     <= 1'b1;
      CS      <= 1'b1;
      MOSI    <= 1'b1;
      DC      <= 1'b1;
    end else begin
      state <= state_next;
      if (state_enter) begin
        cnt <= (state_next == GAP) ? GAP_LOAD : HP_LOAD;
      end else if (cnt != 8'd0) begin
        cnt <= cnt - 8'd1;
      end
      if (state_enter) begin
        case (state_next)
          SETUP: begin
            CS      <= 1'b0;
            DC      <= head[8];
            MOSI    <= head[7];
            shreg   <= head[7:0];
            bit_idx <= 3'd7;
          end
          LOW: begin
            SCL     <= 1'b0;
            MOSI    <= shreg[idx_next];
            bit_idx <= idx_next;
          end
          HIGH: SCL <= 1'b1;
          GAP: begin
            CS  <= 1'b1;
            SCL <= 1'b1;
          end
          default: begin
            SCL <= 1'b1;
            CS  <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
